// File: rtl/actuator_start_sequencer.sv
// Staged actuator start-up: channels are enabled one at a time. Each channel
// must confirm its feedback, then dwell, before the next one is enabled.
module actuator_start_sequencer #(
    parameter int N_CH     = 4,
    parameter int STEP_DLY = 1000,
    parameter int FB_TO    = 5000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shutdown_in,
    input  logic            start_req,
    input  logic [N_CH-1:0] fb_ok,
    input  logic            ack_pulse,
    output logic [N_CH-1:0] en_o,
    output logic            busy_o,
    output logic            all_on_o,
    output logic            seq_fault_o,
    output logic [2:0]      fault_ch_o
);

    localparam int KW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_FB, DWELL, RUN, FAULT} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [15:0]     timer;
    logic            start_prev;
    logic            start_rise;
    logic            below_hit;
    logic [2:0]      below_idx;
    logic            any_hit;
    logic [2:0]      any_idx;

    assign start_rise = start_req & ~start_prev;

    // Lowest-index lost feedback: descending loop, last hit wins.
    always_comb begin
        below_hit = 1'b0;
        below_idx = '0;
        any_hit   = 1'b0;
        any_idx   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (!fb_ok[j]) begin
                any_hit = 1'b1;
                any_idx = 3'(j);
                if (j < int'(k)) begin
                    below_hit = 1'b1;
                    below_idx = 3'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            timer       <= '0;
            en_o        <= '0;
            seq_fault_o <= 1'b0;
            fault_ch_o  <= '0;
            start_prev  <= 1'b1;
        end else begin
            start_prev <= start_req;
            case (state)
                IDLE: begin
                    if (start_rise && !shutdown_in) begin
                        state <= WAIT_FB;
                        k     <= '0;
                        timer <= '0;
                        en_o  <= N_CH'(1);
                    end
                end
                WAIT_FB: begin
                    // Shutdown outranks every fault and progress condition.
                    if (shutdown_in) begin
                        state <= IDLE;
                        en_o  <= '0;
                        k     <= '0;
                        timer <= '0;
                    end else if (below_hit) begin
                        state       <= FAULT;
                        en_o        <= '0;
                        seq_fault_o <= 1'b1;
                        fault_ch_o  <= below_idx;
                    end else if (fb_ok[k]) begin
                        state <= DWELL;
                        timer <= '0;
                    end else if (timer == 16'(FB_TO - 1)) begin
                        state       <= FAULT;
                        en_o        <= '0;
                        seq_fault_o <= 1'b1;
                        fault_ch_o  <= 3'(k);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DWELL: begin
                    if (shutdown_in) begin
                        state <= IDLE;
                        en_o  <= '0;
                        k     <= '0;
                        timer <= '0;
                    end else if (below_hit) begin
                        state       <= FAULT;
                        en_o        <= '0;
                        seq_fault_o <= 1'b1;
                        fault_ch_o  <= below_idx;
                    end else if (timer == 16'(STEP_DLY - 1)) begin
                        timer <= '0;
                        if (k == KW'(N_CH - 1)) begin
                            state <= RUN;
                        end else begin
                            k     <= k + 1'b1;
                            en_o  <= en_o | (N_CH'(1) << (k + 1'b1));
                            state <= WAIT_FB;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RUN: begin
                    if (shutdown_in) begin
                        state <= IDLE;
                        en_o  <= '0;
                        k     <= '0;
                    end else if (any_hit) begin
                        state       <= FAULT;
                        en_o        <= '0;
                        seq_fault_o <= 1'b1;
                        fault_ch_o  <= any_idx;
                    end else if (!start_req) begin
                        state <= IDLE;
                        en_o  <= '0;
                        k     <= '0;
                    end
                end
                FAULT: begin
                    en_o <= '0;
                    if (ack_pulse && !start_req) begin
                        state       <= IDLE;
                        seq_fault_o <= 1'b0;
                        k           <= '0;
                        timer       <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    en_o  <= '0;
                end
            endcase
        end
    end

    assign busy_o   = (state == WAIT_FB) || (state == DWELL);
    assign all_on_o = (state == RUN);

endmodule

// File: doc/actuator_start_sequencer.md
ACTUATOR_START_SEQUENCER -- requirements
Module: actuator_start_sequencer

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of actuator channels, legal range 1..8.
REQ-002 The block SHALL have parameter STEP_DLY, default 1000, meaning dwell cycles between a channel's feedback acceptance and the next channel's enable, legal range 1..65535.
REQ-003 The block SHALL have parameter FB_TO, default 5000, meaning feedback-timeout cycles per channel, legal range 1..65535.
REQ-004 The block SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port shutdown_in  in  1  shutdown demand from the ESD FSM, high = stop.
REQ-007 The block SHALL have port start_req  in  1  operator start request, acted on at its rising edge only.
REQ-008 The block SHALL have port fb_ok  in  N_CH  per-channel energized confirmation.
REQ-009 The block SHALL have port ack_pulse  in  1  one-cycle sequencer fault-clear pulse.
REQ-010 The block SHALL have port en_o  out  N_CH  registered channel enables.
REQ-011 The block SHALL have port busy_o  out  1  sequence in progress.
REQ-012 The block SHALL have port all_on_o  out  1  all channels confirmed.
REQ-013 The block SHALL have port seq_fault_o  out  1  latched sequencer fault.
REQ-014 The block SHALL have port fault_ch_o  out  3  index of the faulting channel.

Function
REQ-015 The block SHALL implement the states IDLE, WAIT_FB, DWELL, RUN and FAULT, with an internal channel index k and a 16-bit timer.
REQ-016 In IDLE, a start_req rising edge (0 on the previous edge, 1 on the current edge) with shutdown_in=0 SHALL move the FSM to WAIT_FB with k=0 and set en_o[0]=1 at that same edge.
REQ-017 The WAIT_FB timer SHALL be 0 on entry and SHALL increment each cycle; fb_ok[k]=1 at any edge SHALL move the FSM to DWELL.
REQ-018 In WAIT_FB, if timer==FB_TO-1 with fb_ok[k]=0, the FSM SHALL move to FAULT with fault_ch_o=k.
REQ-019 DWELL SHALL last exactly STEP_DLY cycles; at its final edge the FSM SHALL move to RUN if k==N_CH-1, otherwise it SHALL increment k, set en_o[k+1]=1 and enter WAIT_FB.
REQ-020 A start_req deassertion in RUN SHALL clear en_o to 0 and return the FSM to IDLE at the next edge.
REQ-021 In WAIT_FB, DWELL or RUN, any already-confirmed channel j (j<k, or any j in RUN) with fb_ok[j]=0 SHALL move the FSM to FAULT with fault_ch_o set to the lowest such j.
REQ-022 shutdown_in=1 in WAIT_FB, DWELL or RUN SHALL clear en_o to 0 and move the FSM to IDLE at the next edge, and this SHALL take priority over timeout, feedback loss and dwell completion (no fault is raised).
REQ-023 shutdown_in=1 in FAULT SHALL leave the FSM in FAULT.
REQ-024 After shutdown, the block SHALL restart only on a new start_req rising edge; a start_req held high SHALL NOT restart it.
REQ-025 In FAULT, en_o SHALL be 0 and seq_fault_o SHALL be 1.
REQ-026 In FAULT, ack_pulse with start_req=0 SHALL move the FSM to IDLE and clear seq_fault_o; ack_pulse with start_req=1 SHALL be ignored.
REQ-027 fault_ch_o SHALL hold its value until the next FAULT entry and SHALL be cleared only by reset.
REQ-028 busy_o SHALL be 1 exactly in WAIT_FB and DWELL; all_on_o SHALL be 1 exactly in RUN.
REQ-029 busy_o and all_on_o SHALL be decoded from registered state only.
REQ-030 en_o SHALL only ever have the pattern of bits 0..k set (thermometer), with no other enable pattern produced.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, k=0, timer=0, en_o=0, busy_o=0, all_on_o=0, seq_fault_o=0, fault_ch_o=0, and the start_req history register to 1, so that a start_req already high at reset release does not start the sequence.

Verification (N_CH=4, STEP_DLY=10, FB_TO=20)
REQ-032 Normal start: start_req rising edge, with fb_ok[k] echoing en_o[k] after 3 cycles -> en_o steps 0001, 0011, 0111, 1111; each new bit rises 10 cycles after the previous acceptance; all_on_o=1, busy_o=0.
REQ-033 Timeout: fb_ok[2] held at 0 -> on the 20th cycle in WAIT_FB for channel 2, seq_fault_o=1, fault_ch_o=2, en_o=0000.
REQ-034 Mid-sequence shutdown: shutdown_in=1 while en_o=0011 -> next edge en_o=0000, IDLE, seq_fault_o=0; with start_req held high, no restart occurs until start_req goes 0 then 1.
REQ-035 Feedback loss in RUN: fb_ok[1] drops -> FAULT with fault_ch_o=1 and en_o=0000; ack_pulse with start_req=1 is ignored; ack_pulse with start_req=0 -> IDLE, seq_fault_o=0.
REQ-036 Simultaneous events: shutdown_in=1 on the same edge as the FB_TO expiry -> IDLE, seq_fault_o=0.
REQ-037 Reset mid-DWELL: rst_n asserted between edges -> all outputs 0 immediately, before the next clock edge.
